// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480@60 timing constants and receiver state type.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int H_TOTAL      = 800;
    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_W     = 96;
    localparam int V_TOTAL      = 525;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_W     = 2;
    localparam int LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_edge
//  Description : Registers an active-low sync input and flags its edges.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync_n,
    output logic level,
    output logic fall,
    output logic rise
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        sync_d = sync_n;
        prev_d = sync_q;
    end

    // Idle level of an active-low sync is high, so reset must not fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign fall  = ~sync_q &  prev_q;
    assign rise  =  sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_rx.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_rx
//  Description : Locks a flywheel x/y counter to incoming hs/vs and flags errors.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_rx #(
    parameter  int H_TOTAL      = vga_timing_pkg::H_TOTAL,
    parameter  int H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
    parameter  int H_SYNC_START = vga_timing_pkg::H_SYNC_START,
    parameter  int H_SYNC_W     = vga_timing_pkg::H_SYNC_W,
    parameter  int V_TOTAL      = vga_timing_pkg::V_TOTAL,
    parameter  int V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
    parameter  int V_SYNC_START = vga_timing_pkg::V_SYNC_START,
    parameter  int V_SYNC_W     = vga_timing_pkg::V_SYNC_W,
    parameter  int LOCK_FRAMES  = vga_timing_pkg::LOCK_FRAMES,
    parameter  int ERR_W        = 16,
    localparam int XW           = $clog2(H_TOTAL + 1),
    localparam int YW           = $clog2(V_TOTAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_n,
    input  logic             vs_n,
    output logic [XW-1:0]    x,
    output logic [YW-1:0]    y,
    output logic             draw,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    import vga_timing_pkg::*;

    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [XW-1:0] C_X_LAST    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] C_X_ACTIVE  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] C_HS_START  = XW'(H_SYNC_START);
    localparam logic [XW-1:0] C_HS_END    = XW'(H_SYNC_START + H_SYNC_W);
    localparam logic [YW-1:0] C_Y_LAST    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] C_Y_ACTIVE  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] C_VS_START  = YW'(V_SYNC_START);
    localparam logic [YW-1:0] C_VS_END    = YW'(V_SYNC_START + V_SYNC_W);
    localparam logic [GW-1:0] C_LOCK      = GW'(LOCK_FRAMES);

    rx_state_t        state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [GW-1:0]    good_q, good_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic w_hs_lvl, w_hs_fall, w_hs_rise;
    logic w_vs_lvl, w_vs_fall, w_vs_rise;
    logic w_unused_edges;
    logic w_exp_hs_n, w_exp_vs_n, w_mismatch, w_err;
    logic w_x_wrap, w_frame_wrap;
    logic [XW-1:0] w_x_next;
    logic [YW-1:0] w_y_next;

    vga_sync_edge u_hs_edge (
        .clk    (clk),
        .rst    (rst),
        .sync_n (hs_n),
        .level  (w_hs_lvl),
        .fall   (w_hs_fall),
        .rise   (w_hs_rise)
    );

    vga_sync_edge u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .sync_n (vs_n),
        .level  (w_vs_lvl),
        .fall   (w_vs_fall),
        .rise   (w_vs_rise)
    );

    // Only the vs falling edge anchors the flywheel; level compare covers the rest.
    assign w_unused_edges = w_hs_fall | w_hs_rise | w_vs_rise;

    always_comb begin
        w_exp_hs_n   = ~((x_q >= C_HS_START) && (x_q < C_HS_END));
        w_exp_vs_n   = ~((y_q >= C_VS_START) && (y_q < C_VS_END));
        w_mismatch   = (w_hs_lvl != w_exp_hs_n) || (w_vs_lvl != w_exp_vs_n);
        w_err        = (state_q != SEARCH) && w_mismatch;
        w_x_wrap     = (x_q == C_X_LAST);
        w_frame_wrap = w_x_wrap && (y_q == C_Y_LAST);
        w_x_next     = w_x_wrap ? '0 : x_q + XW'(1);
        w_y_next     = !w_x_wrap ? y_q : ((y_q == C_Y_LAST) ? '0 : y_q + YW'(1));

        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            SEARCH: begin
                x_d = '0;
                y_d = '0;
                // The vs edge is the pixel x=0 of line V_SYNC_START, so the next one is x=1.
                if (w_vs_fall) begin
                    state_d = ACQUIRE;
                    x_d     = XW'(1);
                    y_d     = C_VS_START;
                    good_d  = '0;
                end
            end
            ACQUIRE, LOCKED: begin
                if (w_mismatch) begin
                    state_d = SEARCH;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    x_d = w_x_next;
                    y_d = w_y_next;
                    if ((state_q == ACQUIRE) && w_frame_wrap) begin
                        good_d = good_q + GW'(1);
                        if (good_d == C_LOCK) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            default: begin
                state_d = SEARCH;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        if (w_err && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            x_q       <= '0;
            y_q       <= '0;
            good_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            good_q    <= good_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign locked    = (state_q == LOCKED);
    assign draw      = locked && (x_q < C_X_ACTIVE) && (y_q < C_Y_ACTIVE);
    assign err       = w_err;
    assign err_count = err_cnt_q;

endmodule
`default_nettype wire
